// File: rtl/paddle_ctrl.sv
// Two-player paddle controller: synchronised, debounced up/down buttons move each
// paddle centre on a slow tick with on-screen clamping, plus a registered paddle-pixel flag.

module paddle_btn_deb #(
  parameter logic [19:0] DEB_MAX = 20'd250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o
);
  logic [1:0]  sync_q, sync_d;
  logic        db_q, db_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    db_d   = db_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_MAX - 20'd1) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign btn_o = db_q;
endmodule

module paddle_ctrl #(
  parameter logic [24:0] TICK_MAX = 25'd500000,
  parameter logic [19:0] DEB_MAX  = 20'd250000,
  parameter logic [9:0]  STEP     = 10'd4,
  parameter logic [9:0]  HALF_H   = 10'd50,
  parameter logic [9:0]  Y_MIN    = 10'd50,
  parameter logic [9:0]  Y_MAX    = 10'd430,
  parameter logic [9:0]  Y_INIT   = 10'd240,
  parameter logic [9:0]  P1_X0    = 10'd580,
  parameter logic [9:0]  P1_X1    = 10'd590,
  parameter logic [9:0]  P2_X0    = 10'd60,
  parameter logic [9:0]  P2_X1    = 10'd70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic [9:0] hsp,
  input  logic [9:0] vsp,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic       paddle_pix
);
  localparam int NUM_BTN = 4;

  // Button order: {p2_dn, p2_up, p1_dn, p1_up}
  logic [NUM_BTN-1:0] btn_raw, btn_db;
  assign btn_raw = {p2_dn, p2_up, p1_dn, p1_up};

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
      paddle_btn_deb #(.DEB_MAX(DEB_MAX)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn_i(btn_raw[g]),
        .btn_o(btn_db[g])
      );
    end
  endgenerate

  logic [24:0]     tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [1:0][9:0] y_q, y_d;
  logic            pix_q, pix_d;

  // Clamp is tested before the subtract/add so the 10-bit value never wraps.
  function automatic logic [9:0] move_y(input logic [9:0] y, input logic up, input logic dn);
    move_y = y;
    if (up && !dn)
      move_y = (y < Y_MIN + STEP) ? Y_MIN : y - STEP;
    else if (dn && !up)
      move_y = (y > Y_MAX - STEP) ? Y_MAX : y + STEP;
  endfunction

  function automatic logic on_pad(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] x0, input logic [9:0] x1,
                                  input logic [9:0] c);
    on_pad = (x >= x0) && (x < x1) && (y >= c - HALF_H) && (y <= c + HALF_H);
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_MAX - 25'd1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 25'd1;
    y_d        = y_q;
    if (tick) begin
      y_d[0] = move_y(y_q[0], btn_db[0], btn_db[1]);
      y_d[1] = move_y(y_q[1], btn_db[2], btn_db[3]);
    end
    pix_d = on_pad(hsp, vsp, P1_X0, P1_X1, y_q[0]) ||
            on_pad(hsp, vsp, P2_X0, P2_X1, y_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      y_q        <= {Y_INIT, Y_INIT};
      pix_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
    end
  end

  assign p1_y       = y_q[0];
  assign p2_y       = y_q[1];
  assign paddle_pix = pix_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus queues expected paddle moves and timed samples,
// a negedge monitor pops and compares whenever a paddle moves or a sample falls due.

module tb_paddle_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] hsp = '0, vsp = '0;
  logic [9:0] p1_y, p2_y;
  logic       paddle_pix;

  paddle_ctrl #(.TICK_MAX(25'd10), .DEB_MAX(20'd4)) dut (
    .clk(clk), .rst(rst),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .hsp(hsp), .vsp(vsp),
    .p1_y(p1_y), .p2_y(p2_y), .paddle_pix(paddle_pix)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct {int due; int sel; int exp; string nm;} smp_t;
  smp_t sq[$];
  int   q1[$], q2[$];
  logic [9:0] prev1 = 10'd240, prev2 = 10'd240;

  function automatic int dut_val(input int sel);
    case (sel)
      0:       return int'(p1_y);
      1:       return int'(p2_y);
      default: return int'(paddle_pix);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: timed samples plus every paddle movement event
  always @(negedge clk) begin
    smp_t s;
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      if (s.due < cyc) chk({s.nm, " stale"}, s.due, cyc);
      else             chk(s.nm, dut_val(s.sel), s.exp);
    end
    if (rst) begin
      prev1 = p1_y;
      prev2 = p2_y;
    end else begin
      if (p1_y != prev1) begin
        if (q1.size() == 0) chk("p1_y unexpected move", int'(p1_y), int'(prev1));
        else                chk("p1_y move", int'(p1_y), q1.pop_front());
        prev1 = p1_y;
      end
      if (p2_y != prev2) begin
        if (q2.size() == 0) chk("p2_y unexpected move", int'(p2_y), int'(prev2));
        else                chk("p2_y move", int'(p2_y), q2.pop_front());
        prev2 = p2_y;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_s(input int dly, input int sel, input int exp, input string nm);
    smp_t s;
    s.due = cyc + dly; s.sel = sel; s.exp = exp; s.nm = nm;
    sq.push_back(s);
  endtask

  task automatic pix(input int h, input int v, input int e, input string nm);
    hsp = h[9:0];
    vsp = v[9:0];
    push_s(1, 2, e, nm);
    step(1);
  endtask

  task automatic wait_y(input int sel, input int val, input int budget);
    int n = 0;
    while (dut_val(sel) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach target", dut_val(sel), val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(3);
    push_s(0, 0, 240, "reset p1_y");
    push_s(0, 1, 240, "reset p2_y");
    push_s(0, 2, 0,   "reset paddle_pix");
    step(1);
    rst = 1'b0;
    step(2);

    // Pixel decode with both centres at 240
    pix(585, 190, 1, "pix p1 top edge");
    pix(585, 291, 0, "pix p1 below");
    pix(585, 290, 1, "pix p1 bottom edge");
    pix(590, 240, 0, "pix p1 x1 exclusive");
    pix(579, 240, 0, "pix p1 left of x0");
    pix(60,  290, 1, "pix p2 corner");
    pix(69,  190, 1, "pix p2 last col");
    pix(70,  240, 0, "pix p2 x1 exclusive");
    pix(65,  189, 0, "pix p2 above");
    pix(300, 240, 0, "pix mid screen");
    step(2);

    // Both buttons across several ticks: no movement
    p1_up = 1'b1; p1_dn = 1'b1;
    step(60);
    p1_up = 1'b0; p1_dn = 1'b0;
    step(12);

    // 3-cycle glitch ignored, then a stable press accepted
    p1_dn = 1'b1;
    step(3);
    p1_dn = 1'b0;
    step(20);
    p1_dn = 1'b1;
    q1.push_back(244);
    wait_y(0, 244, 40);
    p1_dn = 1'b0;
    step(12);

    // Hold up: one step per tick, p2 untouched
    p1_up = 1'b1;
    q1.push_back(240); q1.push_back(236); q1.push_back(232); q1.push_back(228);
    wait_y(0, 228, 80);
    p1_up = 1'b0;
    step(12);

    // Asynchronous reset mid-count and mid-debounce; tick phase restarts from 0
    hsp = 10'd585; vsp = 10'd228;
    p1_up = 1'b1;
    step(4);
    rst = 1'b1;
    push_s(0, 0, 240, "async reset p1_y");
    push_s(0, 1, 240, "async reset p2_y");
    push_s(0, 2, 0,   "async reset paddle_pix");
    step(2);
    rst = 1'b0;
    push_s(9,  0, 240, "p1_y before first tick");
    push_s(10, 0, 236, "p1_y at first tick");
    q1.push_back(236);
    wait_y(0, 236, 30);
    p1_up = 1'b0;
    step(12);

    // Top clamp: 240 down to 52, then 50 and hold
    p2_up = 1'b1;
    for (int k = 1; k <= 47; k++) q2.push_back(240 - 4 * k);
    q2.push_back(50);
    wait_y(1, 50, 700);
    step(50);
    p2_up = 1'b0;
    step(3);
    rst = 1'b1;
    push_s(0, 1, 240, "reset p2_y after clamp");
    step(2);
    rst = 1'b0;
    step(10);

    // Bottom clamp: 244 up to 428, then 430 and hold
    p2_dn = 1'b1;
    for (int k = 1; k <= 47; k++) q2.push_back(240 + 4 * k);
    q2.push_back(430);
    wait_y(1, 430, 700);
    step(60);
    p2_dn = 1'b0;
    step(12);

    chk("p1 moves outstanding", q1.size(), 0);
    chk("p2 moves outstanding", q2.size(), 0);
    chk("samples outstanding",  sq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
